// File: rtl/cart_pkg.sv
// Shared types and constants for the MBC5 cartridge responder.
package cart_pkg;

  // Region tag latched for the read path.
  typedef enum logic [1:0] {
    RGN_ROM0 = 2'd0,
    RGN_ROMX = 2'd1,
    RGN_RAM  = 2'd2,
    RGN_OPEN = 2'd3
  } region_e;

  // Register window bases inside 0000-7FFF.
  localparam logic [15:0] WIN_RAM_EN   = 16'h0000;
  localparam logic [15:0] WIN_ROM_LO   = 16'h2000;
  localparam logic [15:0] WIN_ROM_HI   = 16'h3000;
  localparam logic [15:0] WIN_RAM_BANK = 16'h4000;

  // Low-nibble value that enables external RAM.
  localparam logic [3:0] RAM_EN_KEY = 4'hA;

endpackage

// File: rtl/cart_mbc5_responder_if.sv
// Console cartridge bus: the console drives strobes/address/data, the cartridge returns read data.
interface cart_mbc5_responder_if;
  logic        n_cart_clk;
  logic        cart_write;
  logic        cart_read;
  logic        cart_cs;
  logic [15:0] cart_addr;
  logic [7:0]  cart_wdata;
  logic [7:0]  cart_rdata;

  modport master (
    output n_cart_clk, cart_write, cart_read, cart_cs, cart_addr, cart_wdata,
    input  cart_rdata
  );

  modport slave (
    input  n_cart_clk, cart_write, cart_read, cart_cs, cart_addr, cart_wdata,
    output cart_rdata
  );
endinterface

// File: rtl/cart_mbc5_responder_bank_regs.sv
// MBC5 write-commit detector and banking registers (ram_en, rom_bank, ram_bank).
module mbc5_bank_regs
  import cart_pkg::*;
#(
  parameter int ROM_BANK_BITS = 9,
  parameter int RAM_BANK_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_n_cart_clk,
  input  logic                     i_cart_write,
  input  logic                     i_cart_cs,
  input  logic [3:0]               i_addr_hi,
  input  logic [7:0]               i_cart_wdata,
  output logic                     o_commit,
  output logic                     o_ram_en,
  output logic [ROM_BANK_BITS-1:0] o_rom_bank,
  output logic [RAM_BANK_BITS-1:0] o_ram_bank
);

  // Working width for the split 8+1 bit ROM bank write.
  localparam int EXT_BITS = (ROM_BANK_BITS > 9) ? ROM_BANK_BITS : 9;

  logic                     r_n_cart_clk;
  logic                     r_ram_en;
  logic [ROM_BANK_BITS-1:0] r_rom_bank;
  logic [RAM_BANK_BITS-1:0] r_ram_bank;

  logic                     w_commit;
  logic                     w_reg_wr;
  logic                     w_ram_en_nxt;
  logic [EXT_BITS-1:0]      w_rom_ext;
  logic [RAM_BANK_BITS-1:0] w_ram_bank_nxt;

  // Rising edge of n_cart_clk with the write strobe held; reset value 1 blocks a commit on the first edge.
  assign w_commit = ~r_n_cart_clk & i_n_cart_clk & i_cart_write;
  assign w_reg_wr = w_commit & ~i_cart_cs & ~i_addr_hi[3];

  // Decode the register window and compute next register values.
  always_comb begin
    w_ram_en_nxt   = r_ram_en;
    w_ram_bank_nxt = r_ram_bank;
    w_rom_ext      = EXT_BITS'(r_rom_bank);
    if (w_reg_wr) begin
      if (i_addr_hi[3:1] == WIN_RAM_EN[15:13]) begin
        w_ram_en_nxt = (i_cart_wdata[3:0] == RAM_EN_KEY);
      end else if (i_addr_hi == WIN_ROM_LO[15:12]) begin
        w_rom_ext[7:0] = i_cart_wdata;
      end else if (i_addr_hi == WIN_ROM_HI[15:12]) begin
        w_rom_ext[8] = i_cart_wdata[0];
      end else if (i_addr_hi[3:1] == WIN_RAM_BANK[15:13]) begin
        w_ram_bank_nxt = i_cart_wdata[RAM_BANK_BITS-1:0];
      end
    end
  end

  // Bus clock history and banking register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_cart_clk <= 1'b1;
      r_ram_en     <= 1'b0;
      r_rom_bank   <= ROM_BANK_BITS'(1);
      r_ram_bank   <= '0;
    end else begin
      r_n_cart_clk <= i_n_cart_clk;
      r_ram_en     <= w_ram_en_nxt;
      r_rom_bank   <= w_rom_ext[ROM_BANK_BITS-1:0];
      r_ram_bank   <= w_ram_bank_nxt;
    end
  end

  assign o_commit   = w_commit;
  assign o_ram_en   = r_ram_en;
  assign o_rom_bank = r_rom_bank;
  assign o_ram_bank = r_ram_bank;

endmodule

// File: rtl/cart_mbc5_responder.sv
// MBC5 cartridge responder: bus decode, ROM/RAM mapping, read mux and save-dirty tracking.
// Optional build macro CART_RUMBLE_EN: ram_bank[3] drives rumble instead of RAM addressing.
module cart_mbc5_responder
  import cart_pkg::*;
#(
  parameter int ROM_BANK_BITS = 9,
  parameter int RAM_BANK_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  cart_mbc5_responder_if.slave        bus,
  output logic [14+ROM_BANK_BITS-1:0] rom_addr,
  input  logic [7:0]                  rom_rdata,
  output logic [13+RAM_BANK_BITS-1:0] ram_addr,
  output logic [7:0]                  ram_wdata,
  output logic                        ram_write,
  input  logic [7:0]                  ram_rdata,
  output logic                        save_dirty,
  input  logic                        save_ack,
  output logic                        rumble
);

  logic                     w_commit;
  logic                     w_ram_en;
  logic [ROM_BANK_BITS-1:0] w_rom_bank;
  logic [RAM_BANK_BITS-1:0] w_ram_bank;
  logic [ROM_BANK_BITS-1:0] w_rom_bank_sel;
  region_e                  w_tag_nxt;
  region_e                  r_tag;
  logic                     r_save_dirty;

  mbc5_bank_regs #(
    .ROM_BANK_BITS (ROM_BANK_BITS),
    .RAM_BANK_BITS (RAM_BANK_BITS)
  ) u_bank_regs (
    .clk          (clk),
    .reset        (reset),
    .i_n_cart_clk (bus.n_cart_clk),
    .i_cart_write (bus.cart_write),
    .i_cart_cs    (bus.cart_cs),
    .i_addr_hi    (bus.cart_addr[15:12]),
    .i_cart_wdata (bus.cart_wdata),
    .o_commit     (w_commit),
    .o_ram_en     (w_ram_en),
    .o_rom_bank   (w_rom_bank),
    .o_ram_bank   (w_ram_bank)
  );

  // Lower ROM window is fixed at bank 0; upper window uses the bank register (bank 0 allowed).
  assign w_rom_bank_sel = bus.cart_addr[14] ? w_rom_bank : '0;
  assign rom_addr       = {w_rom_bank_sel, bus.cart_addr[13:0]};

`ifdef CART_RUMBLE_EN
  assign ram_addr = {{(RAM_BANK_BITS-3){1'b0}}, w_ram_bank[2:0], bus.cart_addr[12:0]};
  assign rumble   = w_ram_bank[3];
`else
  assign ram_addr = {w_ram_bank, bus.cart_addr[12:0]};
  assign rumble   = 1'b0;
`endif

  assign ram_write = w_commit & bus.cart_cs & w_ram_en;
  assign ram_wdata = bus.cart_wdata;

  // Classify the current access for the next-cycle read mux.
  always_comb begin
    w_tag_nxt = RGN_OPEN;
    if (bus.cart_read) begin
      if (!bus.cart_addr[15]) begin
        w_tag_nxt = bus.cart_addr[14] ? RGN_ROMX : RGN_ROM0;
      end else if (bus.cart_cs && w_ram_en) begin
        w_tag_nxt = RGN_RAM;
      end
    end
  end

  // Region tag register and save-dirty flag (a RAM write beats a same-cycle acknowledge).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag        <= RGN_OPEN;
      r_save_dirty <= 1'b0;
    end else begin
      r_tag <= w_tag_nxt;
      if (ram_write) begin
        r_save_dirty <= 1'b1;
      end else if (save_ack) begin
        r_save_dirty <= 1'b0;
      end
    end
  end

  // Read data mux driven by the registered tag.
  always_comb begin
    bus.cart_rdata = 8'hFF;
    case (r_tag)
      RGN_ROM0, RGN_ROMX: bus.cart_rdata = rom_rdata;
      RGN_RAM:            bus.cart_rdata = ram_rdata;
      default:            bus.cart_rdata = 8'hFF;
    endcase
  end

  assign save_dirty = r_save_dirty;

endmodule

// File: tb/tb_cart_mbc5_responder.sv
// Randomized self-checking bench for cart_mbc5_responder against an address-arithmetic model.
module tb_cart_mbc5_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] rom_addr;
  logic [7:0]  rom_rdata;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_write;
  logic [7:0]  ram_rdata;
  logic        save_dirty;
  logic        save_ack;
  logic        rumble;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;

  // Reference model state
  int m_ram_en, m_rom_bank, m_ram_bank, m_dirty;

  cart_mbc5_responder_if bus ();

  cart_mbc5_responder #(
    .ROM_BANK_BITS (9),
    .RAM_BANK_BITS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .rom_addr   (rom_addr),
    .rom_rdata  (rom_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_write  (ram_write),
    .ram_rdata  (ram_rdata),
    .save_dirty (save_dirty),
    .save_ack   (save_ack),
    .rumble     (rumble)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_write === 1'b1) n_pulses++;

  function automatic void model_reset();
    m_ram_en = 0; m_rom_bank = 1; m_ram_bank = 0; m_dirty = 0;
  endfunction

  function automatic int exp_rumble();
`ifdef CART_RUMBLE_EN
    return (m_ram_bank / 8) % 2;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_rom_addr(int a);
    if (a < 'h4000) return a;
    return (m_rom_bank % 512) * 16384 + (a % 16384);
  endfunction

  function automatic int exp_ram_addr(int a);
`ifdef CART_RUMBLE_EN
    return (m_ram_bank % 8) * 8192 + (a % 8192);
`else
    return (m_ram_bank % 16) * 8192 + (a % 8192);
`endif
  endfunction

  function automatic int exp_rdata(int a, bit cs, bit rd, int rom_d, int ram_d);
    if (!rd) return 'hFF;
    if (a < 'h8000) return rom_d;
    if (cs && m_ram_en != 0) return ram_d;
    return 'hFF;
  endfunction

  // Apply a committed write to the model.
  function automatic void model_write(int a, int d, bit cs);
    if (cs) begin
      if (m_ram_en != 0) m_dirty = 1;
    end else if (a < 'h2000) m_ram_en = ((d % 16) == 10) ? 1 : 0;
    else if (a < 'h3000) m_rom_bank = (m_rom_bank / 256) * 256 + d;
    else if (a < 'h4000) m_rom_bank = (m_rom_bank % 256) + (d % 2) * 256;
    else if (a < 'h6000) m_ram_bank = d % 16;
  endfunction

  // Drives one bus write cycle; samples the RAM port in the commit cycle.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic cs,
                           output logic wr_seen, output logic [16:0] ra_seen, output logic [7:0] wd_seen);
    @(negedge clk);
    bus.cart_addr = a; bus.cart_wdata = d; bus.cart_cs = cs;
    bus.cart_read = 1'b0; bus.cart_write = 1'b1; bus.n_cart_clk = 1'b0;
    @(negedge clk);
    bus.n_cart_clk = 1'b1;
    #1;
    wr_seen = ram_write; ra_seen = ram_addr; wd_seen = ram_wdata;
    @(negedge clk);
    bus.cart_write = 1'b0; bus.cart_cs = 1'b0;
    #1;
  endtask

  // Drives one read access with fresh memory data; returns mapped addresses and read data.
  task automatic bus_read(input logic [15:0] a, input logic cs, input logic rd,
                          output logic [22:0] rom_a, output logic [16:0] ram_a, output logic [7:0] rdata,
                          output int rom_d, output int ram_d);
    @(negedge clk);
    bus.cart_addr = a; bus.cart_cs = cs; bus.cart_read = rd; bus.cart_write = 1'b0;
    rom_rdata = 8'($urandom); ram_rdata = 8'($urandom);
    rom_d = int'(rom_rdata); ram_d = int'(ram_rdata);
    #1;
    rom_a = rom_addr; ram_a = ram_addr;
    @(negedge clk);
    #1;
    rdata = bus.cart_rdata;
    bus.cart_read = 1'b0; bus.cart_cs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.n_cart_clk = 1'b1; bus.cart_write = 1'b0; bus.cart_read = 1'b0; bus.cart_cs = 1'b0;
    bus.cart_addr = 16'h4000; bus.cart_wdata = 8'h00; save_ack = 1'b0;
    rom_rdata = 8'h00; ram_rdata = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.cart_rdata !== 8'hFF) $display("FAIL reset_rdata got=%h exp=ff", bus.cart_rdata); else n_pass++;
    n_checks++; if (rom_addr !== 23'h004000) $display("FAIL reset_rom_addr got=%h exp=004000", rom_addr); else n_pass++;
    n_checks++; if (ram_addr !== 17'(exp_ram_addr('h4000))) $display("FAIL reset_ram_addr got=%h exp=%h", ram_addr, 17'(exp_ram_addr('h4000))); else n_pass++;
    n_checks++; if ({ram_write, save_dirty, rumble} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {ram_write, save_dirty, rumble}); else n_pass++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_rom_banking();
    logic w; logic [16:0] ra; logic [7:0] wd, rd; logic [22:0] roa; logic [16:0] rma; int romd, ramd;
    bus_read(16'h4000, 1'b0, 1'b1, roa, rma, rd, romd, ramd);
    n_checks++; if (roa !== 23'h004000) $display("FAIL rom_bank1 got=%h exp=004000", roa); else n_pass++;
    n_checks++; if (rd !== 8'(romd)) $display("FAIL rom_read1 got=%h exp=%h", rd, 8'(romd)); else n_pass++;
    bus_write(16'h2000, 8'h05, 1'b0, w, ra, wd); model_write('h2000, 'h05, 0);
    bus_write(16'h3000, 8'h01, 1'b0, w, ra, wd); model_write('h3000, 'h01, 0);
    bus_read(16'h4123, 1'b0, 1'b1, roa, rma, rd, romd, ramd);
    n_checks++; if (roa !== {9'h105, 14'h0123}) $display("FAIL rom_bank105 got=%h exp=%h", roa, {9'h105, 14'h0123}); else n_pass++;
    bus_read(16'h0123, 1'b0, 1'b1, roa, rma, rd, romd, ramd);
    n_checks++; if (roa !== 23'h000123) $display("FAIL rom_region0 got=%h exp=000123", roa); else n_pass++;
    bus_write(16'h2ABC, 8'h00, 1'b0, w, ra, wd); model_write('h2ABC, 'h00, 0);
    bus_write(16'h3FFF, 8'hFE, 1'b0, w, ra, wd); model_write('h3FFF, 'hFE, 0);
    bus_read(16'h7FFF, 1'b0, 1'b1, roa, rma, rd, romd, ramd);
    n_checks++; if (roa !== 23'h003FFF) $display("FAIL rom_bank0_upper got=%h exp=003fff", roa); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      int lo, hi, a;
      lo = $urandom_range(0, 255); hi = $urandom_range(0, 255);
      bus_write(16'h2000, 8'(lo), 1'b0, w, ra, wd); model_write('h2000, lo, 0);
      bus_write(16'h3000, 8'(hi), 1'b0, w, ra, wd); model_write('h3000, hi, 0);
      a = $urandom_range('h4000, 'h7FFF);
      bus_read(16'(a), 1'b0, 1'b1, roa, rma, rd, romd, ramd);
      n_checks++; if (roa !== 23'(exp_rom_addr(a))) $display("FAIL rom_rand got=%h exp=%h", roa, 23'(exp_rom_addr(a))); else n_pass++;
    end
  endtask

  task automatic test_ram_enable();
    logic w; logic [16:0] ra; logic [7:0] wd, rd; logic [22:0] roa; logic [16:0] rma; int romd, ramd, p0;
    bus_write(16'h0000, 8'h00, 1'b0, w, ra, wd); model_write('h0000, 'h00, 0);
    bus_write(16'h4000, 8'h00, 1'b0, w, ra, wd); model_write('h4000, 'h00, 0);
    bus_read(16'hA000, 1'b1, 1'b1, roa, rma, rd, romd, ramd);
    n_checks++; if (rd !== 8'hFF) $display("FAIL ram_disabled_read got=%h exp=ff", rd); else n_pass++;
    p0 = n_pulses;
    bus_write(16'hA010, 8'h5A, 1'b1, w, ra, wd); model_write('hA010, 'h5A, 1);
    n_checks++; if ((n_pulses - p0) !== 0 || w !== 1'b0) $display("FAIL ram_disabled_write got=%0d exp=0", n_pulses - p0); else n_pass++;
    n_checks++; if (save_dirty !== 1'(m_dirty)) $display("FAIL dirty_after_drop got=%b exp=%0d", save_dirty, m_dirty); else n_pass++;
    bus_write(16'h0000, 8'h0A, 1'b0, w, ra, wd); model_write('h0000, 'h0A, 0);
    p0 = n_pulses;
    bus_write(16'hA010, 8'h5A, 1'b1, w, ra, wd); model_write('hA010, 'h5A, 1);
    n_checks++; if ((n_pulses - p0) !== 1 || w !== 1'b1) $display("FAIL ram_write_pulse got=%0d exp=1", n_pulses - p0); else n_pass++;
    n_checks++; if (ra !== 17'h00010) $display("FAIL ram_write_addr got=%h exp=00010", ra); else n_pass++;
    n_checks++; if (wd !== 8'h5A) $display("FAIL ram_write_data got=%h exp=5a", wd); else n_pass++;
    n_checks++; if (save_dirty !== 1'b1) $display("FAIL dirty_set got=%b exp=1", save_dirty); else n_pass++;
  endtask

  task automatic test_ram_bank_read();
    logic w; logic [16:0] ra; logic [7:0] wd, rd; logic [22:0] roa; logic [16:0] rma; int romd, ramd;
    bus_write(16'h4000, 8'h03, 1'b0, w, ra, wd); model_write('h4000, 'h03, 0);
    bus_read(16'hBFFF, 1'b1, 1'b1, roa, rma, rd, romd, ramd);
    n_checks++; if (rma !== {4'h3, 13'h1FFF}) $display("FAIL ram_bank3_addr got=%h exp=%h", rma, {4'h3, 13'h1FFF}); else n_pass++;
    n_checks++; if (rd !== 8'(ramd)) $display("FAIL ram_read got=%h exp=%h", rd, 8'(ramd)); else n_pass++;
    bus_read(16'hBFFF, 1'b1, 1'b0, roa, rma, rd, romd, ramd);
    n_checks++; if (rd !== 8'hFF) $display("FAIL read_gated got=%h exp=ff", rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int p0;
    @(negedge clk); save_ack = 1'b1;
    @(negedge clk); save_ack = 1'b0; m_dirty = 0; #1;
    n_checks++; if (save_dirty !== 1'b0) $display("FAIL dirty_ack_clear got=%b exp=0", save_dirty); else n_pass++;
    p0 = n_pulses;
    @(negedge clk);
    bus.cart_addr = 16'hA020; bus.cart_wdata = 8'h11; bus.cart_cs = 1'b1; bus.cart_write = 1'b1; bus.n_cart_clk = 1'b0;
    @(negedge clk); bus.n_cart_clk = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.n_cart_clk = 1'b0;
    @(negedge clk); bus.n_cart_clk = 1'b1; save_ack = 1'b1;
    @(negedge clk); save_ack = 1'b0;
    @(negedge clk); bus.cart_write = 1'b0; bus.cart_cs = 1'b0; #1;
    m_dirty = 1;
    n_checks++; if ((n_pulses - p0) !== 2) $display("FAIL held_write_commits got=%0d exp=2", n_pulses - p0); else n_pass++;
    n_checks++; if (save_dirty !== 1'(m_dirty)) $display("FAIL dirty_set_wins got=%b exp=1", save_dirty); else n_pass++;
  endtask

  task automatic test_random();
    logic w; logic [16:0] ra; logic [7:0] wd, rd; logic [22:0] roa; logic [16:0] rma; int romd, ramd;
    for (int i = 0; i < 60; i++) begin
      int op, a, d, p0;
      bit cs, rdn;
      op = $urandom_range(0, 3);
      d  = $urandom_range(0, 255);
      if (op == 0) begin
        a = $urandom_range(0, 'h7FFF);
        if (a < 'h2000 && $urandom_range(0, 1) == 1) d = (d / 16) * 16 + 10;
        bus_write(16'(a), 8'(d), 1'b0, w, ra, wd);
        model_write(a, d, 0);
      end else if (op == 1) begin
        a = $urandom_range('hA000, 'hBFFF);
        p0 = n_pulses;
        bus_write(16'(a), 8'(d), 1'b1, w, ra, wd);
        n_checks++; if ((n_pulses - p0) !== m_ram_en) $display("FAIL rand_ram_pulse got=%0d exp=%0d", n_pulses - p0, m_ram_en); else n_pass++;
        if (m_ram_en != 0) begin
          n_checks++; if (ra !== 17'(exp_ram_addr(a)) || wd !== 8'(d)) $display("FAIL rand_ram_port got=%h/%h exp=%h/%h", ra, wd, 17'(exp_ram_addr(a)), 8'(d)); else n_pass++;
        end
        model_write(a, d, 1);
        n_checks++; if (save_dirty !== 1'(m_dirty)) $display("FAIL rand_dirty got=%b exp=%0d", save_dirty, m_dirty); else n_pass++;
      end else if (op == 2) begin
        a   = $urandom_range(0, 'hFFFF);
        cs  = (a >= 'hA000 && a < 'hC000) ? 1'($urandom_range(0, 1)) : 1'b0;
        rdn = ($urandom_range(0, 3) != 0);
        bus_read(16'(a), cs, rdn, roa, rma, rd, romd, ramd);
        if (a < 'h8000) begin
          n_checks++; if (roa !== 23'(exp_rom_addr(a))) $display("FAIL rand_rom_addr a=%h got=%h exp=%h", a, roa, 23'(exp_rom_addr(a))); else n_pass++;
        end
        n_checks++; if (rma !== 17'(exp_ram_addr(a))) $display("FAIL rand_ram_addr a=%h got=%h exp=%h", a, rma, 17'(exp_ram_addr(a))); else n_pass++;
        n_checks++; if (rd !== 8'(exp_rdata(a, cs, rdn, romd, ramd))) $display("FAIL rand_rdata a=%h got=%h exp=%h", a, rd, 8'(exp_rdata(a, cs, rdn, romd, ramd))); else n_pass++;
      end else begin
        @(negedge clk); save_ack = 1'b1;
        @(negedge clk); save_ack = 1'b0; m_dirty = 0; #1;
        n_checks++; if (save_dirty !== 1'b0) $display("FAIL rand_ack got=%b exp=0", save_dirty); else n_pass++;
      end
      n_checks++; if (rumble !== 1'(exp_rumble())) $display("FAIL rand_rumble got=%b exp=%0d", rumble, exp_rumble()); else n_pass++;
    end
  endtask

  task automatic test_rumble();
    logic w; logic [16:0] ra; logic [7:0] wd, rd; logic [22:0] roa; logic [16:0] rma; int romd, ramd;
    bus_write(16'h4000, 8'h0B, 1'b0, w, ra, wd); model_write('h4000, 'h0B, 0);
    bus_read(16'hA000, 1'b1, 1'b1, roa, rma, rd, romd, ramd);
    n_checks++; if (rumble !== 1'(exp_rumble())) $display("FAIL rumble_on got=%b exp=%0d", rumble, exp_rumble()); else n_pass++;
    n_checks++; if (rma !== 17'(exp_ram_addr('hA000))) $display("FAIL rumble_bank_field got=%h exp=%h", rma, 17'(exp_ram_addr('hA000))); else n_pass++;
  endtask

  task automatic test_reset_midcycle();
    logic w; logic [16:0] ra; logic [7:0] wd;
    bus_write(16'h0000, 8'h0A, 1'b0, w, ra, wd); model_write('h0000, 'h0A, 0);
    bus_write(16'h2000, 8'h77, 1'b0, w, ra, wd); model_write('h2000, 'h77, 0);
    @(negedge clk);
    bus.cart_addr = 16'hA000; bus.cart_wdata = 8'hC3; bus.cart_cs = 1'b1; bus.cart_write = 1'b1; bus.n_cart_clk = 1'b0;
    @(negedge clk);
    bus.n_cart_clk = 1'b1; reset = 1'b0; model_reset(); #1;
    n_checks++; if (ram_write !== 1'b0) $display("FAIL midreset_no_write got=%b exp=0", ram_write); else n_pass++;
    n_checks++; if ({save_dirty, rumble} !== 2'b00) $display("FAIL midreset_flags got=%b exp=00", {save_dirty, rumble}); else n_pass++;
    n_checks++; if (bus.cart_rdata !== 8'hFF) $display("FAIL midreset_rdata got=%h exp=ff", bus.cart_rdata); else n_pass++;
    bus.cart_cs = 1'b0; bus.cart_write = 1'b0; bus.cart_addr = 16'h4000; #1;
    n_checks++; if (rom_addr !== 23'(exp_rom_addr('h4000))) $display("FAIL midreset_rom_bank got=%h exp=%h", rom_addr, 23'(exp_rom_addr('h4000))); else n_pass++;
    bus.cart_addr = 16'h2000; bus.cart_wdata = 8'h33; bus.cart_write = 1'b1;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    bus.cart_write = 1'b0; bus.cart_addr = 16'h4000; #1;
    n_checks++; if (rom_addr !== 23'(exp_rom_addr('h4000))) $display("FAIL first_edge_no_commit got=%h exp=%h", rom_addr, 23'(exp_rom_addr('h4000))); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rom_banking();
    test_ram_enable();
    test_ram_bank_read();
    test_back_to_back();
    test_random();
    test_rumble();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cart_mbc5_responder.md
# cart_mbc5_responder

Cartridge-side responder for the console's cartridge bus, emulating an MBC5 memory bank controller. It decodes the bus cycles the console's cartridge controller drives, maintains the ROM/RAM banking registers and the RAM enable, and maps each access onto external synchronous ROM and save-RAM ports. It sits outside the console, in place of a physical cartridge, and tracks unsaved RAM writes for the host save logic.

## Interface

- ROM_BANK_BITS, 9: implemented ROM bank register width; ROM bank count is 2^ROM_BANK_BITS, 16 KiB each.
- RAM_BANK_BITS, 4: implemented RAM bank register width; RAM bank count is 2^RAM_BANK_BITS, 8 KiB each.
- clk  in  1  system clock (8.388608 MHz, same domain as the console).
- reset  in  1  asynchronous, active-low reset.
- n_cart_clk  in  1  bus clock from the console; a write commits on its rising edge.
- cart_write  in  1  bus write strobe.
- cart_read  in  1  bus read strobe.
- cart_cs  in  1  external-RAM chip select (A000–BFFF), active-high.
- cart_addr  in  16  bus address.
- cart_wdata  in  8  bus write data.
- cart_rdata  out  8  bus read data.
- rom_addr  out  14+ROM_BANK_BITS  ROM byte address (combinational).
- rom_rdata  in  8  ROM data; valid one clk after rom_addr.
- ram_addr  out  13+RAM_BANK_BITS  save-RAM byte address.
- ram_wdata  out  8  save-RAM write data.
- ram_write  out  1  save-RAM write pulse.
- ram_rdata  in  8  save-RAM data; valid one clk after ram_addr.
- save_dirty  out  1  RAM modified since last acknowledge.
- save_ack  in  1  host has saved RAM; clears save_dirty.
- rumble  out  1  rumble motor drive (see Configuration).

## Operation

- Write commit: a register records n_cart_clk. A commit occurs in the single clk cycle where the recorded value is 0 and the current value is 1, while cart_write=1. At most one commit per n_cart_clk period.
- Register writes on commit, with cart_cs=0 and cart_addr[15]=0:
  - 0000–1FFF: ram_en <= (wdata[3:0]==4'hA).
  - 2000–2FFF: rom_bank[7:0] <= wdata.
  - 3000–3FFF: rom_bank[8] <= wdata[0] (ignored if ROM_BANK_BITS<9).
  - 4000–5FFF: ram_bank <= wdata[RAM_BANK_BITS-1:0].
  - 6000–7FFF: no effect.
- Upper bits beyond the parameter widths are discarded. Bank indices wrap modulo the bank count. ROM bank 0 is legal in the 4000–7FFF window.
- Address mapping (combinational):
  - Region 0000–3FFF: rom_addr = {0, addr[13:0]}.
  - Region 4000–7FFF: rom_addr = {rom_bank, addr[13:0]}.
  - RAM: ram_addr = {ram_bank, addr[12:0]}.
- RAM write: a commit with cart_cs=1 and ram_en=1 produces ram_write=1 for exactly that cycle, with ram_wdata=cart_wdata, and sets save_dirty.
- A RAM write while ram_en=0 is dropped.
- Read path: region tag is registered each clk from the current address:
  - ROM when addr[15]=0.
  - RAM when cart_cs=1 and ram_en=1.
  - OPEN otherwise.
- cart_rdata, one clk later, selects rom_rdata, ram_rdata or 8'hFF according to the tag. cart_read only gates the tag; OPEN is forced when cart_read=0.
- save_dirty set/clear: set by a RAM write, cleared by save_ack. If both happen in the same cycle, set wins.

## Timing

- Reset values:
  - ram_en=0, rom_bank=1, ram_bank=0.
  - Tag=OPEN, so cart_rdata=8'hFF.
  - ram_write=0, save_dirty=0, rumble=0.
  - Recorded n_cart_clk=1, so there is no commit on the first edge after reset.
- Register update is visible on rom_addr and ram_addr in the clk cycle after the commit.
- Read latency: 1 clk from stable address to valid cart_rdata.
- Reset asserted mid-bus-cycle: all state returns to reset values immediately. No partial write is issued.

## Configuration

- CART_RUMBLE_EN:
  - Defined: ram_bank[3] is not part of RAM addressing. ram_addr uses ram_bank[2:0], and rumble follows the written ram_bank[3].
  - Undefined: rumble is tied to 0 and all RAM_BANK_BITS address RAM.

## Structure

- A shared package cart_pkg holds:
  - The region enum (ROM0, ROMX, RAM, OPEN).
  - The register window base constants (16'h0000, 16'h2000, 16'h3000, 16'h4000).
  - The 4'hA enable key.
- One sub-module, mbc5_bank_regs, holds the commit edge detector and the banking registers. The top level holds the mapping, the read mux and save_dirty.

## Test plan

- Reset, then read 4000 -> rom_addr=16'h4000 (bank 1); cart_rdata=8'hFF before the first read.
- Write 8'h05 to 2000, then 8'h01 to 3000, then read 4123 -> rom_addr={9'h105, 14'h0123}.
- Read A000 with ram_en=0 -> cart_rdata=8'hFF, no ram_write. Write 8'h0A to 0000, then write 8'h5A to A010 -> single ram_write pulse, ram_addr=17'h00010, save_dirty=1.
- Write 8'h03 to 4000, then read BFFF -> ram_addr={4'h3, 13'h1FFF}, cart_rdata equals ram_rdata one clk later.
- Hold cart_write=1 across two n_cart_clk rising edges -> exactly two commits. Apply save_ack coincident with a RAM write -> save_dirty stays 1.
- With CART_RUMBLE_EN defined, write 8'h0B to 4000 -> rumble=1 and ram_addr bank field=3'h3. Assert reset mid-cycle -> rumble=0, rom_bank=1.
